// File: rtl/multi_seq_ctrl.sv
// multi_seq_ctrl: sequencing FSM for the shift-add multiplier datapath.
// It owns the bit counter, the start/done handshake and accumulator clear/enable.
// In signed mode it subtracts the MSB partial product.
// Outputs are decoded from the state, counter and latched-mode flops.
// STALL is the one live input that reaches an output: it masks the per-cycle
// strobes (ACC_EN, CTRL_IN_A, CARRY_IN) during a stalled RUN cycle, so the
// datapath never loads a partial product that is being held.
module multi_seq_ctrl #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned IDXW  = $clog2(WIDTH)
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            START,
   input  logic            MODE_SIGNED,
   input  logic            STALL,
   output logic            BUSY,
   output logic            DONE,
   output logic            ACC_CLR,
   output logic            ACC_EN,
   output logic [IDXW-1:0] BIT_IDX,
   output logic            CTRL_IN_A,
   output logic            CARRY_IN
);

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [IDXW-1:0] cnt_q, cnt_d;
   logic            signed_q, signed_d;

   // State, bit counter and latched mode; synchronous reset drops any operation
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         signed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         signed_q <= signed_d;
      end
   end

   // Next-state logic: START only accepted in IDLE, STALL only honoured in RUN
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      signed_d = signed_q;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               state_d  = S_CLEAR;
               signed_d = MODE_SIGNED;
               cnt_d    = '0;
            end
         end
         S_CLEAR: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            if (!STALL) begin
               if (cnt_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + IDXW'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode; per-cycle strobes are masked while RUN is stalled
   always_comb begin
      BUSY      = 1'b0;
      DONE      = 1'b0;
      ACC_CLR   = 1'b0;
      ACC_EN    = 1'b0;
      BIT_IDX   = '0;
      CTRL_IN_A = 1'b0;
      CARRY_IN  = 1'b0;
      case (state_q)
         S_CLEAR: begin
            BUSY    = 1'b1;
            ACC_CLR = 1'b1;
         end
         S_RUN: begin
            BUSY    = 1'b1;
            BIT_IDX = cnt_q;
            if (!STALL) begin
               ACC_EN = 1'b1;
               // MSB partial product of a signed operand is subtracted
               if (signed_q && (cnt_q == LAST_IDX)) begin
                  CTRL_IN_A = 1'b1;
                  CARRY_IN  = 1'b1;
               end
            end
         end
         S_DONE: begin
            DONE    = 1'b1;
            BIT_IDX = cnt_q;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_multi_seq_ctrl.sv
// Directed bench for multi_seq_ctrl: one WIDTH=8 instance and one WIDTH=5 instance.
// Cycle n starts at rising edge n. Inputs for cycle n are driven 1ns after that edge.
// Outputs are sampled 4ns later, before the falling edge.
module tb_multi_seq_ctrl;

   logic clk;

   logic       a_rst, a_start, a_ms, a_stall;
   logic       a_busy, a_done, a_clr, a_en, a_inv, a_cin;
   logic [2:0] a_idx;

   logic       b_rst, b_start, b_ms, b_stall;
   logic       b_busy, b_done, b_clr, b_en, b_inv, b_cin;
   logic [2:0] b_idx;

   int checks = 0;
   int errors = 0;

   multi_seq_ctrl #(.WIDTH(8)) dut_a (
      .CLK(clk), .RST(a_rst), .START(a_start), .MODE_SIGNED(a_ms), .STALL(a_stall),
      .BUSY(a_busy), .DONE(a_done), .ACC_CLR(a_clr), .ACC_EN(a_en),
      .BIT_IDX(a_idx), .CTRL_IN_A(a_inv), .CARRY_IN(a_cin)
   );

   multi_seq_ctrl #(.WIDTH(5)) dut_b (
      .CLK(clk), .RST(b_rst), .START(b_start), .MODE_SIGNED(b_ms), .STALL(b_stall),
      .BUSY(b_busy), .DONE(b_done), .ACC_CLR(b_clr), .ACC_EN(b_en),
      .BIT_IDX(b_idx), .CTRL_IN_A(b_inv), .CARRY_IN(b_cin)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected output word: {BUSY, DONE, ACC_CLR, ACC_EN, CTRL_IN_A, CARRY_IN, BIT_IDX}
   function automatic logic [13:0] ev(input logic busy, done, clr, en, inv, cin,
                                      input int idx);
      return {busy, done, clr, en, inv, cin, 8'(idx)};
   endfunction

   function automatic logic [13:0] obs_a();
      return {a_busy, a_done, a_clr, a_en, a_inv, a_cin, 8'(a_idx)};
   endfunction

   function automatic logic [13:0] obs_b();
      return {b_busy, b_done, b_clr, b_en, b_inv, b_cin, 8'(b_idx)};
   endfunction

   task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b (busy,done,clr,en,inv,cin,idx[7:0])",
                tag, obs, exp);
      end
   endtask

   // One cycle on instance A: drive inputs, then check that cycle's outputs
   task automatic cyc_a(input logic rst, st, ms, sl, input logic [13:0] exp,
                        input string tag);
      @(posedge clk);
      #1;
      a_rst = rst; a_start = st; a_ms = ms; a_stall = sl;
      #3;
      chk(tag, obs_a(), exp);
   endtask

   task automatic cyc_b(input logic rst, st, ms, sl, input logic [13:0] exp,
                        input string tag);
      @(posedge clk);
      #1;
      b_rst = rst; b_start = st; b_ms = ms; b_stall = sl;
      #3;
      chk(tag, obs_b(), exp);
   endtask

   localparam logic [13:0] ZERO = 14'd0;

   initial begin
      a_rst = 1'b1; a_start = 1'b0; a_ms = 1'b0; a_stall = 1'b0;
      b_rst = 1'b1; b_start = 1'b0; b_ms = 1'b0; b_stall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      a_rst = 1'b0; b_rst = 1'b0;
      #3;
      chk("reset_a", obs_a(), ZERO);
      chk("reset_b", obs_b(), ZERO);

      // 1) unsigned, no stall: CLEAR at 1, bits 0..7 at 2..9, DONE at 10
      cyc_a(0, 1, 0, 0, ZERO, "u_c0_idle");
      cyc_a(0, 0, 0, 0, ev(1,0,1,0,0,0,0), "u_c1_clear");
      for (int c = 2; c <= 9; c++)
         cyc_a(0, 0, 1, 0, ev(1,0,0,1,0,0,c-2), $sformatf("u_c%0d_run", c));
      cyc_a(0, 0, 0, 0, ev(0,1,0,0,0,0,7), "u_c10_done");
      cyc_a(0, 0, 0, 0, ZERO, "u_c11_idle");

      // 2) signed latched at START; MODE_SIGNED dropped from cycle 3 on
      cyc_a(0, 1, 1, 0, ZERO, "s_c0_idle");
      cyc_a(0, 0, 1, 0, ev(1,0,1,0,0,0,0), "s_c1_clear");
      cyc_a(0, 0, 1, 0, ev(1,0,0,1,0,0,0), "s_c2_run");
      for (int c = 3; c <= 8; c++)
         cyc_a(0, 0, 0, 0, ev(1,0,0,1,0,0,c-2), $sformatf("s_c%0d_run", c));
      cyc_a(0, 0, 0, 0, ev(1,0,0,1,1,1,7), "s_c9_msb");
      cyc_a(0, 0, 0, 0, ev(0,1,0,0,0,0,7), "s_c10_done");
      cyc_a(0, 0, 0, 0, ZERO, "s_c11_idle");

      // 3) unsigned with STALL in cycles 4-5: bit 2 held through 6, DONE at 12
      cyc_a(0, 1, 0, 0, ZERO, "st_c0_idle");
      cyc_a(0, 0, 0, 1, ev(1,0,1,0,0,0,0), "st_c1_clear_stall_ignored");
      cyc_a(0, 0, 0, 0, ev(1,0,0,1,0,0,0), "st_c2_run");
      cyc_a(0, 0, 0, 0, ev(1,0,0,1,0,0,1), "st_c3_run");
      cyc_a(0, 0, 0, 1, ev(1,0,0,0,0,0,2), "st_c4_stall");
      cyc_a(0, 0, 0, 1, ev(1,0,0,0,0,0,2), "st_c5_stall");
      for (int c = 6; c <= 11; c++)
         cyc_a(0, 0, 0, 0, ev(1,0,0,1,0,0,c-4), $sformatf("st_c%0d_run", c));
      cyc_a(0, 0, 0, 0, ev(0,1,0,0,0,0,7), "st_c12_done");
      cyc_a(0, 0, 0, 0, ZERO, "st_c13_idle");

      // 4) signed, stall on the MSB cycle masks the subtract strobes
      cyc_a(0, 1, 1, 0, ZERO, "sm_c0_idle");
      cyc_a(0, 0, 1, 0, ev(1,0,1,0,0,0,0), "sm_c1_clear");
      for (int c = 2; c <= 8; c++)
         cyc_a(0, 0, 1, 0, ev(1,0,0,1,0,0,c-2), $sformatf("sm_c%0d_run", c));
      cyc_a(0, 0, 1, 1, ev(1,0,0,0,0,0,7), "sm_c9_msb_stalled");
      cyc_a(0, 0, 1, 0, ev(1,0,0,1,1,1,7), "sm_c10_msb");
      cyc_a(0, 0, 1, 0, ev(0,1,0,0,0,0,7), "sm_c11_done");
      cyc_a(0, 0, 0, 0, ZERO, "sm_c12_idle");

      // 5) START held high: ignored while busy/done, next CLEAR at 12
      cyc_a(0, 1, 0, 0, ZERO, "h_c0_idle");
      cyc_a(0, 1, 0, 0, ev(1,0,1,0,0,0,0), "h_c1_clear");
      for (int c = 2; c <= 9; c++)
         cyc_a(0, 1, 0, 0, ev(1,0,0,1,0,0,c-2), $sformatf("h_c%0d_run", c));
      cyc_a(0, 1, 0, 0, ev(0,1,0,0,0,0,7), "h_c10_done");
      cyc_a(0, 1, 0, 0, ZERO, "h_c11_idle");
      cyc_a(0, 0, 0, 0, ev(1,0,1,0,0,0,0), "h_c12_clear");
      for (int c = 13; c <= 20; c++)
         cyc_a(0, 0, 0, 0, ev(1,0,0,1,0,0,c-13), $sformatf("h_c%0d_run", c));
      cyc_a(0, 0, 0, 0, ev(0,1,0,0,0,0,7), "h_c21_done");
      cyc_a(0, 0, 0, 0, ZERO, "h_c22_idle");

      // 6) RST at cycle 5 mid-RUN drops the operation; fresh START at 7 -> DONE at 17
      cyc_a(0, 1, 1, 0, ZERO, "r_c0_idle");
      cyc_a(0, 0, 0, 0, ev(1,0,1,0,0,0,0), "r_c1_clear");
      for (int c = 2; c <= 4; c++)
         cyc_a(0, 0, 0, 0, ev(1,0,0,1,0,0,c-2), $sformatf("r_c%0d_run", c));
      cyc_a(1, 0, 0, 0, ev(1,0,0,1,0,0,3), "r_c5_rst_asserted");
      cyc_a(0, 0, 0, 0, ZERO, "r_c6_after_rst");
      cyc_a(0, 1, 0, 0, ZERO, "r_c7_idle_start");
      cyc_a(0, 0, 0, 0, ev(1,0,1,0,0,0,0), "r_c8_clear");
      for (int c = 9; c <= 16; c++)
         cyc_a(0, 0, 0, 0, ev(1,0,0,1,0,0,c-9), $sformatf("r_c%0d_run", c));
      cyc_a(0, 0, 0, 0, ev(0,1,0,0,0,0,7), "r_c17_done");
      cyc_a(0, 0, 0, 0, ZERO, "r_c18_idle");

      // 7) WIDTH=5 signed: bits 0..4, subtract on bit 4, DONE at start+7
      cyc_b(0, 1, 1, 0, ZERO, "w5_c0_idle");
      cyc_b(0, 0, 0, 0, ev(1,0,1,0,0,0,0), "w5_c1_clear");
      for (int c = 2; c <= 5; c++)
         cyc_b(0, 0, 0, 0, ev(1,0,0,1,0,0,c-2), $sformatf("w5_c%0d_run", c));
      cyc_b(0, 0, 0, 0, ev(1,0,0,1,1,1,4), "w5_c6_msb");
      cyc_b(0, 0, 0, 0, ev(0,1,0,0,0,0,4), "w5_c7_done");
      cyc_b(0, 0, 0, 0, ZERO, "w5_c8_idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
